// File: rtl/counter_ctrl.sv
// Run/pause/step controller for the LED counter: button edge detection,
// a three-state FSM that owns the count, and a prescaler that paces RUN.
`timescale 1ns/1ps
module counter_ctrl #(
    parameter int unsigned TICK_DIV = 100_000_000,
    parameter int unsigned WIDTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       state,
    output logic             running,
    output logic             wrap
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             running_q, running_d;
    logic             wrap_q, wrap_d;
    logic [3:0]       btn_q, btn_d;

    logic [3:0]       btn_c;
    logic [3:0]       rise_c;
    logic             ev_clr_c, ev_stop_c, ev_start_c, ev_step_c;
    logic [WIDTH-1:0] count_inc_c;
    logic             count_full_c;
    logic             presc_term_c;

    // Rising-edge detect; only the highest-priority event of a cycle survives.
    always_comb begin
        btn_c      = {clr, stop, start, step};
        btn_d      = btn_c;
        rise_c     = btn_c & ~btn_q;
        ev_clr_c   = rise_c[3];
        ev_stop_c  = rise_c[2] & ~rise_c[3];
        ev_start_c = rise_c[1] & ~(|rise_c[3:2]);
        ev_step_c  = rise_c[0] & ~(|rise_c[3:1]);
    end

    always_comb begin
        count_inc_c  = count_q + WIDTH'(1);
        count_full_c = &count_q;
        presc_term_c = (presc_q == PW'(TICK_DIV - 1));
    end

    // Next-state: prescaler defaults to 0 so it only survives while staying in RUN.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = '0;
        wrap_d  = 1'b0;
        unique case (state_q)
            S_IDLE, S_PAUSE: begin
                if (ev_clr_c) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (ev_start_c) begin
                    state_d = S_RUN;
                end else if (ev_step_c) begin
                    state_d = S_PAUSE;
                    count_d = count_inc_c;
                    wrap_d  = count_full_c;
                end
            end
            S_RUN: begin
                if (ev_clr_c) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (ev_stop_c) begin
                    state_d = S_PAUSE;
                end else if (presc_term_c) begin
                    count_d = count_inc_c;
                    wrap_d  = count_full_c;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        running_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            presc_q   <= '0;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
            btn_q     <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            wrap_q    <= wrap_d;
            btn_q     <= btn_d;
        end
    end

    assign count   = count_q;
    assign state   = state_q;
    assign running = running_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl: TICK_DIV=4 instance (a_) and TICK_DIV=1 instance (b_).
`timescale 1ns/1ps
module tb_counter_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a_start = 0, a_stop = 0, a_step = 0, a_clr = 0;
    logic b_start = 0, b_stop = 0, b_step = 0, b_clr = 0;
    logic [3:0] a_count, b_count;
    logic [1:0] a_state, b_state;
    logic a_running, b_running, a_wrap, b_wrap;

    counter_ctrl #(.TICK_DIV(4), .WIDTH(4)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .stop(a_stop), .step(a_step), .clr(a_clr),
        .count(a_count), .state(a_state), .running(a_running), .wrap(a_wrap)
    );

    counter_ctrl #(.TICK_DIV(1), .WIDTH(4)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .stop(b_stop), .step(b_step), .clr(b_clr),
        .count(b_count), .state(b_state), .running(b_running), .wrap(b_wrap)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int       at;
        bit       dut_b;
        string    name;
        logic [7:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // {count, state, running, wrap}
    function automatic void push(input bit dut_b, input int at, input string name,
                                 input logic [3:0] c, input logic [1:0] s,
                                 input logic r, input logic w);
        exp_t e;
        e.at = at; e.dut_b = dut_b; e.name = name; e.exp = {c, s, r, w};
        exp_q.push_back(e);
    endfunction

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares every expectation due at this cycle, away from the active edge.
    always @(negedge clk) begin
        int i;
        logic [7:0] act;
        i = 0;
        while (i < exp_q.size()) begin
            if (exp_q[i].at <= cyc) begin
                act = exp_q[i].dut_b ? {b_count, b_state, b_running, b_wrap}
                                     : {a_count, a_state, a_running, a_wrap};
                n_checks++;
                if (exp_q[i].at == cyc && act === exp_q[i].exp) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s @cyc %0d (due %0d): got cnt=%0d st=%b run=%b wrap=%b, want cnt=%0d st=%b run=%b wrap=%b",
                             exp_q[i].name, cyc, exp_q[i].at, act[7:4], act[3:2], act[1], act[0],
                             exp_q[i].exp[7:4], exp_q[i].exp[3:2], exp_q[i].exp[1], exp_q[i].exp[0]);
                end
                exp_q.delete(i);
            end else begin
                i++;
            end
        end
    end

    int b, c;

    initial begin
        // Reset and idle
        goto(3);
        push(0, 3, "reset_a", 0, 2'b00, 0, 0);
        push(1, 3, "reset_b", 0, 2'b00, 0, 0);
        rst = 1'b0;
        for (int k = 4; k <= 23; k++) begin
            push(0, k, "idle_a", 0, 2'b00, 0, 0);
            push(1, k, "idle_b", 0, 2'b00, 0, 0);
        end
        goto(25);
        b = cyc;

        // Run at TICK_DIV=4, through wrap
        a_start = 1;
        push(0, b+1,  "run_enter",  0,  2'b01, 1, 0);
        push(0, b+4,  "run_pre1",   0,  2'b01, 1, 0);
        push(0, b+5,  "run_cnt1",   1,  2'b01, 1, 0);
        push(0, b+9,  "run_cnt2",   2,  2'b01, 1, 0);
        push(0, b+61, "run_cnt15",  15, 2'b01, 1, 0);
        push(0, b+64, "run_prewrap",15, 2'b01, 1, 0);
        push(0, b+65, "run_wrap",   0,  2'b01, 1, 1);
        push(0, b+66, "run_wrap_end",0, 2'b01, 1, 0);
        goto(b+2);  a_start = 0;

        // Pause at 5, hold for 20 cycles, resume
        goto(b+86); a_stop = 1;
        for (int k = 87; k <= 107; k++) push(0, b+k, "pause_hold", 5, 2'b10, 0, 0);
        goto(b+88); a_stop = 0;
        goto(b+110); a_start = 1;
        push(0, b+111, "resume_enter", 5, 2'b01, 1, 0);
        push(0, b+114, "resume_pre",   5, 2'b01, 1, 0);
        push(0, b+115, "resume_cnt6",  6, 2'b01, 1, 0);
        push(0, b+119, "resume_cnt7",  7, 2'b01, 1, 0);
        goto(b+112); a_start = 0;

        // Stop on the terminal edge: no increment
        goto(b+122); a_stop = 1;
        push(0, b+123, "stop_term",   7, 2'b10, 0, 0);
        push(0, b+126, "stop_term_hold", 7, 2'b10, 0, 0);
        goto(b+124); a_stop = 0;

        // Clear, then steps from IDLE
        goto(b+130); a_clr = 1;
        push(0, b+131, "clr_pause", 0, 2'b00, 0, 0);
        goto(b+132); a_clr = 0;
        goto(b+134); a_step = 1;
        push(0, b+135, "step1", 1, 2'b10, 0, 0);
        goto(b+135); a_step = 0;
        goto(b+137); a_step = 1;
        push(0, b+138, "step2", 2, 2'b10, 0, 0);
        goto(b+138); a_step = 0;
        goto(b+140); a_step = 1;
        push(0, b+141, "step3", 3, 2'b10, 0, 0);
        goto(b+141); a_step = 0;
        goto(b+143); a_step = 1;
        push(0, b+144, "step_held", 4, 2'b10, 0, 0);
        push(0, b+150, "step_held_mid", 4, 2'b10, 0, 0);
        push(0, b+155, "step_held_end", 4, 2'b10, 0, 0);
        goto(b+153); a_step = 0;

        // Step while running is ignored
        goto(b+157); a_start = 1;
        push(0, b+158, "run_again", 4, 2'b01, 1, 0);
        goto(b+158); a_start = 0;
        goto(b+159); a_step = 1;
        push(0, b+160, "step_in_run", 4, 2'b01, 1, 0);
        push(0, b+161, "step_in_run2", 4, 2'b01, 1, 0);
        push(0, b+162, "run_cnt5", 5, 2'b01, 1, 0);
        goto(b+160); a_step = 0;

        // Stop at 15, step across the wrap
        push(0, b+203, "run_to15", 15, 2'b01, 1, 0);
        goto(b+203); a_stop = 1;
        push(0, b+204, "stop_at15", 15, 2'b10, 0, 0);
        goto(b+205); a_stop = 0;
        goto(b+206); a_step = 1;
        push(0, b+207, "step_wrap", 0, 2'b10, 0, 1);
        push(0, b+208, "step_wrap_end", 0, 2'b10, 0, 0);
        goto(b+207); a_step = 0;

        // clr and start together in RUN at 9
        goto(b+210); a_start = 1;
        push(0, b+211, "run3_enter", 0, 2'b01, 1, 0);
        goto(b+212); a_start = 0;
        push(0, b+247, "run3_cnt9", 9, 2'b01, 1, 0);
        goto(b+248); a_clr = 1; a_start = 1;
        push(0, b+249, "clr_beats_start", 0, 2'b00, 0, 0);
        push(0, b+250, "clr_hold", 0, 2'b00, 0, 0);
        goto(b+250); a_clr = 0; a_start = 0;

        // start and step together in IDLE
        goto(b+252); a_start = 1; a_step = 1;
        push(0, b+253, "start_beats_step", 0, 2'b01, 1, 0);
        push(0, b+254, "start_beats_step2", 0, 2'b01, 1, 0);
        push(0, b+257, "run4_cnt1", 1, 2'b01, 1, 0);
        goto(b+254); a_start = 0; a_step = 0;

        // Reset mid-RUN at 7
        push(0, b+281, "run4_cnt7", 7, 2'b01, 1, 0);
        goto(b+282); rst = 1;
        push(0, b+283, "rst_mid_a", 0, 2'b00, 0, 0);
        push(1, b+283, "rst_mid_b", 0, 2'b00, 0, 0);
        goto(b+284); rst = 0;
        push(0, b+285, "post_rst_a", 0, 2'b00, 0, 0);

        // TICK_DIV=1: increment every cycle, stop wins on its edge
        goto(b+290);
        c = cyc;
        b_start = 1;
        push(1, c+1, "b_enter", 0, 2'b01, 1, 0);
        push(1, c+2, "b_cnt1",  1, 2'b01, 1, 0);
        push(1, c+3, "b_cnt2",  2, 2'b01, 1, 0);
        push(1, c+5, "b_cnt4",  4, 2'b01, 1, 0);
        goto(c+2); b_start = 0;
        goto(c+5); b_stop = 1;
        push(1, c+6, "b_stop", 4, 2'b10, 0, 0);
        push(1, c+7, "b_stop_hold", 4, 2'b10, 0, 0);
        goto(c+7); b_stop = 0;

        // Drain with a bounded wait
        for (int k = 0; k < 50 && exp_q.size() > 0; k++) begin
            @(posedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            $display("FAIL drain: %0d expectations never checked, want 0", exp_q.size());
            n_checks += exp_q.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
